// File: rtl/relay_frame_packer_pkg.sv
// Shared constants for the relay frame packer:
// SOF/EOF patterns, marker bytes and framer state encoding.
package relay_frame_packer_pkg;

    localparam logic [7:0] SOF_READER_PAT = 8'h0c;
    localparam logic [7:0] SOF_TAG_PAT    = 8'hf0;
    localparam int         EOF_ZERO_RUN   = 16;

    localparam logic [7:0] MARK_HEAD  = 8'hA5;
    localparam logic [7:0] MARK_TAIL  = 8'h5A;
    localparam logic [7:0] MARK_ABORT = 8'h5F;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } frame_state_t;

    function automatic logic [7:0] sof_pattern(
        input logic       mode,
        input logic [7:0] reader,
        input logic [7:0] tag
    );
        return mode ? reader : tag;
    endfunction

endpackage

// File: rtl/relay_byte_fifo.sv
// Byte FIFO between the framer and the SSP serializer.
// Push while full is ignored; pop reads the head combinationally.
module relay_byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] pop_data,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage array; contents need no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/relay_frame_packer.sv
// Relay frame packer: SOF hunt, MSB-first byte packing, FIFO, SSP out.
// Define RELAY_PACK_MARKER_EN to bracket frames with A5 / 5A|5F markers.
module relay_frame_packer
    import relay_frame_packer_pkg::*;
#(
    parameter int         FIFO_DEPTH = 8,
    parameter int         SSP_DIV    = 8,
    parameter int         EOF_ZEROS  = EOF_ZERO_RUN,
    parameter logic [7:0] SOF_READER = SOF_READER_PAT,
    parameter logic [7:0] SOF_TAG    = SOF_TAG_PAT
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic mode,
    input  logic bit_tick,
    input  logic bit_in,
    output logic ssp_clk,
    output logic ssp_frame,
    output logic ssp_din,
    output logic in_frame,
    output logic overflow
);

    localparam int              DW        = $clog2(SSP_DIV);
    localparam logic [DW-1:0]   DIV_LAST  = DW'(SSP_DIV - 1);
    localparam logic [DW-1:0]   HALF_LAST = DW'(SSP_DIV / 2 - 1);
    localparam logic [4:0]      ZRUN_LAST = 5'(EOF_ZEROS - 1);

    frame_state_t state;
    frame_state_t state_nxt;
    logic [7:0]   history;
    logic [7:0]   history_nxt;
    logic [7:0]   byte_q;
    logic [7:0]   byte_d;
    logic [2:0]   bit_cnt;
    logic [2:0]   bit_cnt_d;
    logic [4:0]   zero_run;
    logic [4:0]   zero_run_d;
    logic         push;
    logic [7:0]   push_data;

    logic [7:0]   fifo_data;
    logic         fifo_full;
    logic         fifo_empty;
    logic         pop;

    logic         busy;
    logic [7:0]   shreg;
    logic [2:0]   bit_idx;
    logic [DW-1:0] div_cnt;
    logic         period_end;

    assign history_nxt = {history[6:0], bit_in};
    assign in_frame    = (state == COLLECT);

    // History of the last eight decoded bits, in every state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        history <= '0;
        else if (bit_tick) history <= history_nxt;
    end

    // Framer next state, packing and push requests.
    always_comb begin
        state_nxt  = state;
        byte_d     = byte_q;
        bit_cnt_d  = bit_cnt;
        zero_run_d = zero_run;
        push       = 1'b0;
        push_data  = byte_q;
        unique case (state)
            IDLE: begin
                if (enable && bit_tick &&
                    history_nxt == sof_pattern(mode, SOF_READER, SOF_TAG)) begin
                    state_nxt  = COLLECT;
                    byte_d     = '0;
                    bit_cnt_d  = '0;
                    zero_run_d = '0;
`ifdef RELAY_PACK_MARKER_EN
                    push       = 1'b1;
                    push_data  = MARK_HEAD;
`endif
                end
            end
            COLLECT: begin
                if (!enable) begin
                    state_nxt = IDLE;
`ifdef RELAY_PACK_MARKER_EN
                    push      = 1'b1;
                    push_data = MARK_ABORT;
`endif
                end else if (bit_tick) begin
                    byte_d     = {byte_q[6:0], bit_in};
                    bit_cnt_d  = bit_cnt + 3'd1;
                    zero_run_d = bit_in ? 5'd0 : zero_run + 5'd1;
                    if (!bit_in && zero_run == ZRUN_LAST) begin
                        state_nxt = IDLE;
`ifdef RELAY_PACK_MARKER_EN
                        push      = 1'b1;
                        push_data = MARK_TAIL;
`endif
                    end else if (bit_cnt == 3'd7) begin
                        push      = 1'b1;
                        push_data = byte_d;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Framer state and packing registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            byte_q   <= '0;
            bit_cnt  <= '0;
            zero_run <= '0;
        end else begin
            state    <= state_nxt;
            byte_q   <= byte_d;
            bit_cnt  <= bit_cnt_d;
            zero_run <= zero_run_d;
        end
    end

    // Sticky drop flag: any push that found the FIFO full.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                 overflow <= 1'b0;
        else if (push && fifo_full) overflow <= 1'b1;
    end

    relay_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign period_end = busy && (div_cnt == DIV_LAST);
    assign pop        = !fifo_empty &&
                        (!busy || (period_end && bit_idx == 3'd7));
    assign ssp_din    = shreg[7];

    // SSP serializer: 8 periods per byte, chained with no gap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy      <= 1'b0;
            shreg     <= '0;
            bit_idx   <= '0;
            div_cnt   <= '0;
            ssp_clk   <= 1'b0;
            ssp_frame <= 1'b0;
        end else if (pop) begin
            busy      <= 1'b1;
            shreg     <= fifo_data;
            bit_idx   <= '0;
            div_cnt   <= '0;
            ssp_clk   <= 1'b0;
            ssp_frame <= 1'b1;
        end else if (busy) begin
            if (period_end) begin
                div_cnt   <= '0;
                ssp_clk   <= 1'b0;
                ssp_frame <= 1'b0;
                if (bit_idx == 3'd7) begin
                    busy  <= 1'b0;
                    shreg <= '0;
                end else begin
                    bit_idx <= bit_idx + 3'd1;
                    shreg   <= {shreg[6:0], 1'b0};
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
                if (div_cnt == HALF_LAST) ssp_clk <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_relay_frame_packer.sv
// Bench for relay_frame_packer: directed relay bit streams,
// SSP bytes decoded by a monitor against an expected-byte queue.
module tb_relay_frame_packer;

    localparam int DIV = 64;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic enable = 1'b0;
    logic mode = 1'b0;
    logic bit_tick = 1'b0;
    logic bit_in = 1'b0;
    logic ssp_clk;
    logic ssp_frame;
    logic ssp_din;
    logic in_frame;
    logic overflow;

    int n_chk = 0;
    int n_fail = 0;
    logic [7:0] sb[$];

    relay_frame_packer #(
        .FIFO_DEPTH (8),
        .SSP_DIV    (DIV)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .mode      (mode),
        .bit_tick  (bit_tick),
        .bit_in    (bit_in),
        .ssp_clk   (ssp_clk),
        .ssp_frame (ssp_frame),
        .ssp_din   (ssp_din),
        .in_frame  (in_frame),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        bit_tick = 1'b1;
        bit_in   = b;
        @(negedge clk);
        bit_tick = 1'b0;
        bit_in   = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    // Last bit of v is the one that causes a push into an idle path.
    task automatic send_byte_lat(input logic [7:0] v);
        for (int i = 7; i >= 1; i--) send_bit(v[i]);
        @(negedge clk);
        bit_tick = 1'b1;
        bit_in   = v[0];
        @(negedge clk);
        bit_tick = 1'b0;
        bit_in   = 1'b0;
        check("lat_not_yet", {31'd0, ssp_frame}, 32'd0);
        @(negedge clk);
        check("lat_frame_start", {31'd0, ssp_frame}, 32'd1);
        check("lat_clk_low", {31'd0, ssp_clk}, 32'd0);
    endtask

    task automatic send_zeros(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b0);
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while (sb.size() != 0 && t < 12000) begin
            @(negedge clk);
            t++;
        end
        check(name, sb.size(), 0);
        repeat (DIV) @(negedge clk);
        check({name, "_idle"}, {29'd0, ssp_clk, ssp_frame, ssp_din}, 32'd0);
    endtask

    // Monitor: rebuild each byte at ssp_clk rising edges.
    initial begin : monitor
        int nb;
        logic [7:0] acc;
        logic [7:0] fr;
        logic [7:0] exp;
        logic prev;
        nb = 0;
        acc = '0;
        fr = '0;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                nb   = 0;
                prev = 1'b0;
            end else begin
                if (ssp_clk && !prev) begin
                    acc = {acc[6:0], ssp_din};
                    fr  = {fr[6:0], ssp_frame};
                    nb++;
                    if (nb == 8) begin
                        nb = 0;
                        n_chk++;
                        if (sb.size() == 0) begin
                            n_fail++;
                            $display("FAIL ssp_byte: unexpected byte %02h frame bits %02h",
                                     acc, fr);
                        end else begin
                            exp = sb.pop_front();
                            if ({fr, acc} !== {8'h80, exp}) begin
                                n_fail++;
                                $display("FAIL ssp_byte: got %02h frame bits %02h expected %02h frame bits 80",
                                         acc, fr, exp);
                            end
                        end
                    end
                end
                prev = ssp_clk;
            end
        end
    end

    initial begin : stim
        int t;
        logic prev;
        int rises;

        repeat (3) @(negedge clk);
        check("reset_outputs",
              {27'd0, ssp_clk, ssp_frame, ssp_din, in_frame, overflow}, 32'd0);
        reset  = 1'b1;
        enable = 1'b1;
        mode   = 1'b1;
        repeat (2) @(negedge clk);

        // Reader frame: A3, 7E, then EOF run.
`ifdef RELAY_PACK_MARKER_EN
        sb.push_back(8'hA5);
`endif
        sb.push_back(8'hA3);
        sb.push_back(8'h7E);
        sb.push_back(8'h00);
`ifdef RELAY_PACK_MARKER_EN
        sb.push_back(8'h5A);
        send_byte_lat(8'h0c);
        send_byte(8'hA3);
`else
        send_byte(8'h0c);
        check("t1_in_frame", {31'd0, in_frame}, 32'd1);
        send_byte_lat(8'hA3);
`endif
        check("t1_in_frame_mid", {31'd0, in_frame}, 32'd1);
        send_byte(8'h7E);
        send_zeros(16);
        check("t1_eof", {31'd0, in_frame}, 32'd0);
        check("t1_no_ovf", {31'd0, overflow}, 32'd0);
        drain("t1_drain");

        // Tag frame overflowing the FIFO behind a slow serializer.
        mode = 1'b0;
        @(negedge clk);
`ifdef RELAY_PACK_MARKER_EN
        sb.push_back(8'hA5);
        for (int i = 1; i <= 8; i++) sb.push_back(8'(i * 8'h11));
`else
        for (int i = 1; i <= 9; i++) sb.push_back(8'(i * 8'h11));
`endif
        send_byte(8'hf0);
        check("t3_in_frame", {31'd0, in_frame}, 32'd1);
        for (int i = 1; i <= 12; i++) send_byte(8'(i * 8'h11));
        send_zeros(16);
        check("t3_overflow", {31'd0, overflow}, 32'd1);
        check("t3_eof", {31'd0, in_frame}, 32'd0);
        drain("t3_drain");
        check("t3_overflow_sticky", {31'd0, overflow}, 32'd1);

        // Enable abort after five frame bits.
        mode = 1'b1;
        @(negedge clk);
`ifdef RELAY_PACK_MARKER_EN
        sb.push_back(8'hA5);
        sb.push_back(8'h5F);
`endif
        send_byte(8'h0c);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        check("t4_in_frame", {31'd0, in_frame}, 32'd1);
        enable = 1'b0;
        @(negedge clk);
        check("t4_abort", {31'd0, in_frame}, 32'd0);
        enable = 1'b1;
        drain("t4_drain");

        // Reset in period 3 of a byte in flight.
        send_byte(8'h0c);
        send_byte(8'h96);
        t = 0;
        while (!ssp_frame && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("t5_frame_seen", {31'd0, ssp_frame}, 32'd1);
        prev  = ssp_clk;
        rises = 0;
        t     = 0;
        while (rises < 4 && t < 8 * DIV) begin
            @(negedge clk);
            if (ssp_clk && !prev) rises++;
            prev = ssp_clk;
            t++;
        end
        check("t5_period3_rises", rises, 4);
        check("t5_clk_high", {31'd0, ssp_clk}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("t5_async_reset",
              {27'd0, ssp_clk, ssp_frame, ssp_din, in_frame, overflow}, 32'd0);
        sb.delete();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // SOF pattern inside payload is plain data.
`ifdef RELAY_PACK_MARKER_EN
        sb.push_back(8'hA5);
`endif
        sb.push_back(8'h0C);
        sb.push_back(8'h55);
        sb.push_back(8'h00);
`ifdef RELAY_PACK_MARKER_EN
        sb.push_back(8'h5A);
`endif
        send_byte(8'h0c);
        send_byte(8'h0c);
        check("t6_in_frame", {31'd0, in_frame}, 32'd1);
        send_byte(8'h55);
        send_zeros(16);
        check("t6_eof", {31'd0, in_frame}, 32'd0);
        drain("t6_drain");
        check("t6_no_ovf", {31'd0, overflow}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
